// File: rtl/rv32i_types.sv
// Shared types for the load/store address unit to L1 data cache request path.
// The request struct widths fix the dmem port widths used by the shim.
package rv32i_types;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_MASK_W = DMEM_DATA_W / 8;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_MASK_W-1:0] rmask;
        logic [DMEM_MASK_W-1:0] wmask;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        SHIM_IDLE   = 2'd0,
        SHIM_BUSY   = 2'd1,
        SHIM_ORPHAN = 2'd2
    } shim_state_t;

endpackage

// File: rtl/dmem_req_reg.sv
// Request register with load enable; one-cycle latency from load to q.
// No backpressure of its own: the owner decides when to load.
module dmem_req_reg
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  dmem_req_t d,
    output dmem_req_t q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dmem_req_shim.sv
// Registers core dmem requests and holds them to the cache until cache_resp; cache sees a request
// one cycle after capture, the response returns combinationally. Flushed requests drain unseen, with a one-entry skid behind them.
module dmem_req_shim
    import rv32i_types::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W/8-1:0] core_rmask,
    input  logic [DATA_W/8-1:0] core_wmask,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_resp,
    output logic [ADDR_W-1:0]   cache_addr,
    output logic [DATA_W/8-1:0] cache_rmask,
    output logic [DATA_W/8-1:0] cache_wmask,
    output logic [DATA_W-1:0]   cache_wdata,
    input  logic [DATA_W-1:0]   cache_rdata,
    input  logic                cache_resp,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    shim_state_t      state, state_next;
    dmem_req_t        core_req, hold_d, hold_q, skid_q;
    logic             hold_load, skid_load;
    logic             skid_vld, skid_vld_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_q, err_next;
    logic             req;

    assign req      = |(core_rmask | core_wmask);
    assign core_req = '{addr: core_addr, rmask: core_rmask, wmask: core_wmask, wdata: core_wdata};

    dmem_req_reg u_hold (.clk(clk), .rst(rst), .load(hold_load), .d(hold_d),   .q(hold_q));
    dmem_req_reg u_skid (.clk(clk), .rst(rst), .load(skid_load), .d(core_req), .q(skid_q));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= SHIM_IDLE;
            skid_vld <= 1'b0;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            skid_vld <= skid_vld_next;
            cnt      <= cnt_next;
            err_q    <= err_next;
        end
    end

    always_comb begin
        state_next    = state;
        hold_load     = 1'b0;
        hold_d        = core_req;
        skid_load     = 1'b0;
        skid_vld_next = skid_vld;
        unique case (state)
            SHIM_IDLE: begin
                if (req) begin
                    hold_load  = 1'b1;
                    state_next = SHIM_BUSY;
                end
            end
            SHIM_BUSY: begin
                if (cache_resp) begin
                    state_next = SHIM_IDLE;
                end else if (flush) begin
                    state_next = SHIM_ORPHAN;
                end
            end
            SHIM_ORPHAN: begin
                if (flush) begin
                    skid_vld_next = 1'b0;
                end else if (req && !skid_vld) begin
                    skid_load     = 1'b1;
                    skid_vld_next = 1'b1;
                end
                // On the orphan's response the queued request goes straight to the cache, no gap.
                if (cache_resp) begin
                    skid_load     = 1'b0;
                    skid_vld_next = 1'b0;
                    if (skid_vld && !flush) begin
                        hold_d     = skid_q;
                        hold_load  = 1'b1;
                        state_next = SHIM_BUSY;
                    end else if (req && !flush) begin
                        hold_load  = 1'b1;
                        state_next = SHIM_BUSY;
                    end else begin
                        state_next = SHIM_IDLE;
                    end
                end
            end
            default: state_next = SHIM_IDLE;
        endcase
    end

    // Counter holds the number of cycles the current cache transaction has been outstanding.
    always_comb begin
        cnt_next = cnt;
        if (cache_resp) begin
            cnt_next = (state_next != SHIM_IDLE) ? CNT_W'(1) : '0;
        end else if (state_next != SHIM_IDLE && cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
        err_next = err_q | (cnt_next == CNT_MAX);
    end

    assign busy        = (state != SHIM_IDLE);
    assign timeout_err = err_q;
    assign core_resp   = rst && (state == SHIM_BUSY) && cache_resp && !flush;
    assign core_rdata  = core_resp ? cache_rdata : '0;
    assign cache_addr  = hold_q.addr;
    assign cache_wdata = hold_q.wdata;
    assign cache_rmask = (rst && busy) ? hold_q.rmask : '0;
    assign cache_wmask = (rst && busy) ? hold_q.wmask : '0;

    a_no_req_in_busy: assert property (@(posedge clk) disable iff (!rst)
        !(state == SHIM_BUSY && req));
    a_no_skid_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(state == SHIM_ORPHAN && skid_vld && req && !flush));

endmodule

// File: tb/tb_dmem_req_shim.sv
module tb_dmem_req_shim;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } exp_req_t;

    logic        clk = 1'b0;
    logic        rst, flush, core_resp, cache_resp, busy, timeout_err;
    logic [31:0] core_addr, core_wdata, core_rdata, cache_addr, cache_wdata, cache_rdata;
    logic [3:0]  core_rmask, core_wmask, cache_rmask, cache_wmask;

    int errors = 0;
    int checks = 0;

    exp_req_t    req_q[$];
    logic [31:0] resp_q[$];
    exp_req_t    e;
    logic [31:0] er;
    logic        prev_busy  = 1'b0;
    logic        prev_cresp = 1'b0;

    dmem_req_shim #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .core_addr(core_addr), .core_rmask(core_rmask), .core_wmask(core_wmask),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_resp(core_resp),
        .cache_addr(cache_addr), .cache_rmask(cache_rmask), .cache_wmask(cache_wmask),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_resp(cache_resp),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        flush       = 1'b0;
        core_rmask  = 4'h0;
        core_wmask  = 4'h0;
        core_wdata  = 32'h0;
        cache_resp  = 1'b0;
        cache_rdata = 32'h0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
        core_addr  = a;
        core_rmask = rm;
        core_wmask = wm;
        core_wdata = wd;
        req_q.push_back('{addr: a, rmask: rm, wmask: wm, wdata: wd});
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: a new cache request starts when busy rises or right after a response that leaves us busy.
    always @(negedge clk) begin
        if (rst) begin
            if (busy && (!prev_busy || prev_cresp)) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cache_req: unexpected request addr=%0h rmask=%0h wmask=%0h",
                             cache_addr, cache_rmask, cache_wmask);
                end else begin
                    e = req_q.pop_front();
                    check("cache_req", {cache_addr, cache_rmask, cache_wmask, cache_wdata},
                          {e.addr, e.rmask, e.wmask, e.wdata});
                end
            end
            if (core_resp) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL core_resp: unexpected response rdata=%0h expected none", core_rdata);
                end else begin
                    er = resp_q.pop_front();
                    check("core_rdata", 72'(core_rdata), 72'(er));
                end
            end else if (cache_resp) begin
                check("rdata_zero", 72'(core_rdata), 72'(0));
            end
        end
        prev_busy  = rst ? busy : 1'b0;
        prev_cresp = cache_resp;
    end

    initial begin
        rst = 1'b0; flush = 1'b0; core_addr = 32'h0; core_rmask = 4'h0; core_wmask = 4'h0;
        core_wdata = 32'h0; cache_resp = 1'b0; cache_rdata = 32'h0;
        tick(); tick(); tick();
        sample();
        check("rst_busy",   72'(busy), 72'(0));
        check("rst_masks",  72'({cache_rmask, cache_wmask}), 72'(0));
        check("rst_addr",   72'({cache_addr, cache_wdata}), 72'(0));
        check("rst_resp",   72'({core_resp, core_rdata}), 72'(0));
        check("rst_err",    72'(timeout_err), 72'(0));
        rst = 1'b1;
        tick();

        // Plain load, answered at N+3.
        issue(32'h1000_0004, 4'hF, 4'h0, 32'h0);
        resp_q.push_back(32'hDEAD_BEEF);
        tick();
        sample();
        check("t1_busy", 72'(busy), 72'(1));
        tick();
        sample();
        check("t1_held", 72'({cache_addr, cache_rmask}), 72'({32'h1000_0004, 4'hF}));
        tick();
        cache_resp = 1'b1; cache_rdata = 32'hDEAD_BEEF;
        sample();
        check("t1_resp", 72'(core_resp), 72'(1));
        tick();
        sample();
        check("t1_idle", 72'({busy, cache_rmask}), 72'(0));
        check("t1_addr_kept", 72'(cache_addr), 72'(32'h1000_0004));
        tick();

        // Flush during a load: response swallowed.
        issue(32'h0000_1100, 4'hF, 4'h0, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        sample();
        check("t2_orphan_held", 72'({busy, cache_rmask}), 72'({1'b1, 4'hF}));
        tick(); tick();
        cache_resp = 1'b1; cache_rdata = 32'h0BAD_0BAD;
        sample();
        check("t2_no_resp", 72'(core_resp), 72'(0));
        tick();
        sample();
        check("t2_idle", 72'(busy), 72'(0));
        tick();

        // Orphaned store with a load queued in the skid.
        issue(32'h0000_4000, 4'h0, 4'h3, 32'hAAAA_5555);
        tick();
        flush = 1'b1;
        tick();
        issue(32'h0000_2000, 4'h1, 4'h0, 32'h0);
        resp_q.push_back(32'h1234_5678);
        sample();
        check("t3_store_held", 72'({cache_wmask, cache_wdata}), 72'({4'h3, 32'hAAAA_5555}));
        tick();
        tick();
        cache_resp = 1'b1; cache_rdata = 32'h0000_0BAD;
        tick();
        sample();
        check("t3_skid_issue", 72'({cache_addr, cache_rmask, cache_wmask}),
              72'({32'h0000_2000, 4'h1, 4'h0}));
        tick();
        cache_resp = 1'b1; cache_rdata = 32'h1234_5678;
        sample();
        check("t3_resp", 72'(core_resp), 72'(1));
        tick();
        sample();
        check("t3_idle", 72'(busy), 72'(0));
        tick();

        // Flush and cache_resp together while BUSY.
        issue(32'h0000_0040, 4'hF, 4'h0, 32'h0);
        tick();
        tick();
        flush = 1'b1; cache_resp = 1'b1; cache_rdata = 32'h5555_AAAA;
        sample();
        check("t4_swallow", 72'(core_resp), 72'(0));
        tick();
        sample();
        check("t4_idle", 72'(busy), 72'(0));
        tick();

        // AMO: read then write to the same address.
        issue(32'h0000_3000, 4'hF, 4'h0, 32'h0);
        resp_q.push_back(32'h0000_0011);
        tick();
        tick();
        cache_resp = 1'b1; cache_rdata = 32'h0000_0011;
        tick();
        issue(32'h0000_3000, 4'h0, 4'hF, 32'h0000_0005);
        resp_q.push_back(32'h0);
        tick();
        sample();
        check("t5_wdata_held", 72'({cache_wmask, cache_wdata}), 72'({4'hF, 32'h5}));
        tick();
        cache_resp = 1'b1;
        sample();
        check("t5_wresp", 72'(core_resp), 72'(1));
        tick();

        // Reset mid-transaction, then a stray response.
        issue(32'h0000_6000, 4'hF, 4'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sample();
        check("t6_dropped", 72'({busy, cache_rmask}), 72'(0));
        tick();
        cache_resp = 1'b1; cache_rdata = 32'h0000_0099;
        sample();
        check("t6_stray", 72'({core_resp, core_rdata}), 72'(0));
        tick();

        // Timeout after 8 outstanding cycles, sticky until reset.
        sample();
        check("t7_err_pre", 72'(timeout_err), 72'(0));
        issue(32'h0000_5000, 4'hF, 4'h0, 32'h0);
        resp_q.push_back(32'h0000_0077);
        tick();
        for (int k = 1; k <= 9; k++) begin
            sample();
            if (k == 7) check("t7_err_c7", 72'(timeout_err), 72'(0));
            if (k == 8) check("t7_err_c8", 72'(timeout_err), 72'(1));
            tick();
        end
        cache_resp = 1'b1; cache_rdata = 32'h0000_0077;
        tick();
        sample();
        check("t7_err_sticky", 72'({timeout_err, busy}), 72'({1'b1, 1'b0}));
        tick();
        rst = 1'b0;
        tick();
        sample();
        check("t7_err_clear", 72'({timeout_err, busy}), 72'(0));
        rst = 1'b1;
        tick();
        tick();

        check("req_q_empty",  72'(req_q.size()), 72'(0));
        check("resp_q_empty", 72'(resp_q.size()), 72'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
